alu_functional_unit: RTL and testbench
======================================

// Module: alu_functional_unit
// PURPOSE
//  Integer functional unit directly downstream of the Tomasulo reservation station.
//  Accepts dispatched ALU instructions (tag, opcode, dest, operand B, operand C).
//  Executes each instruction with single-cycle or iterative-multiply latency.
//  Buffers results in a small FIFO and broadcasts them, one per grant, on the CDB (solution + store_cdb).
// PARAMETERS
//  RESULT_DEPTH  4  result FIFO entries (power of 2, 2..8)
//  MUL_LAT       4  cycles the multiplier stays busy per MUL (>=2)
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high; clears all state
//  run            in   1   dispatch strobe from reservation station
//  instruction_in in   43  {tag[42:40], opcode[39:36], dest[35:32], opB[31:16], opC[15:0]}
//  ready          out  1   unit can accept a dispatch this cycle
//  store_cdb      out  1   solution holds a valid result (FIFO non-empty)
//  solution       out  23  {dest[22:19], tag[18:16], data[15:0]}
//  cdb_grant      in   1   CDB arbiter accepts current solution; pop FIFO
//  illegal_op     out  1   one-cycle pulse: dispatched opcode[3]=1 (memory op)
// BEHAVIOUR
//  Reset values: ready=1, store_cdb=0, solution=0, illegal_op=0, FSM=IDLE, FIFO count=0, pointers=0.
//  Accept condition: run && ready. When run=0 or ready=0, instruction_in is ignored (no queueing).
//  ready = (state==IDLE) && (count < RESULT_DEPTH); purely combinational from registered state.
//  Opcodes (opcode[2:0], opcode[3]=0): 000 ADD, 001 SUB(B-C), 010 AND, 011 OR, 100 XOR,
//    101 SLL B<<C[3:0], 110 SRL B>>C[3:0] (logical), 111 MUL (low 16 bits of B*C).
//  Arithmetic: all results are 16-bit; carry/overflow is discarded, with wrap-around modulo 2^16.
//  Single-cycle ops: result is pushed into the FIFO at the accepting edge.
//    When the FIFO was empty, store_cdb=1 on the next cycle.
//  MUL FSM
//    IDLE -> MUL on accept with opcode 111. Operands, tag and dest are latched; counter is loaded with MUL_LAT-1.
//    MUL: decrement each cycle; ready=0 throughout. At counter==0, push the result and return to IDLE.
//    Total: the result enters the FIFO MUL_LAT cycles after the accept edge.
//    The MUL push is guaranteed to find space: ready required count<DEPTH at accept, and nothing else pushes while in MUL.
//  illegal_op: accept with opcode[3]=1 gives a pulse of 1 cycle. Nothing is pushed, and the state is unchanged.
//  FIFO
//    solution = head entry.
//    store_cdb = (count!=0).
//    Pop when store_cdb && cdb_grant. cdb_grant is ignored when empty.
//    Simultaneous push and pop: count unchanged, both pointers advance.
//      This is legal even at count==RESULT_DEPTH-1.
//    Full (count==RESULT_DEPTH): ready=0. A pop in that cycle re-enables ready the following cycle (no bypass).
//    Pointers wrap modulo RESULT_DEPTH.
//    solution/store_cdb are held stable while store_cdb=1 and cdb_grant=0.
//  Ordering: results leave in completion order, not dispatch order.
//    Example: ADD issued after a MUL completes cannot precede the MUL, since ready=0 during MUL.
//  Reset mid-operation: an in-flight MUL is aborted, FIFO contents are discarded, and store_cdb=0 on the next cycle.
//  The reservation station must re-dispatch; this unit keeps no record of aborted work.
// TESTING
//  1. reset; run=1, instr={tag=3,op=ADD,dest=5,B=0x0010,C=0x0022}
//     -> next cycle store_cdb=1, solution={5,3,0x0032}; grant -> store_cdb=0.
//  2. SUB B=0x0000 C=0x0001 -> data=0xFFFF. SLL B=0x0001 C=0x0013 -> data=0x0008 (shift amount C[3:0]=3).
//  3. MUL tag=2 B=0x0100 C=0x0101 (MUL_LAT=4) -> ready=0 for 4 cycles;
//     solution data=0x0100 (low 16 bits of 0x10100) on the cycle after the push; ready=1 again after return to IDLE.
//  4. cdb_grant=0, dispatch 4 ADDs back-to-back -> count=4, ready=0, solution holds the first result.
//     One grant pops it -> ready=1 the next cycle; all results drain in dispatch order.
//  5. count=2 and grant asserted while accepting an ADD -> count stays 2, order preserved across pointer wrap.
//  6. reset asserted mid-MUL with 2 results queued -> next cycle store_cdb=0, ready=1, no late MUL result appears.
//     Separately: opcode=1000 dispatched -> illegal_op=1 for one cycle, no FIFO change.

Source files
------------

// File: rtl/alu_functional_unit.sv
// Integer ALU functional unit behind the reservation station; results are queued and broadcast on the CDB.
// Latency: single-cycle ops are visible on solution one cycle after accept; MUL pushes MUL_LAT cycles after accept.
// Backpressure: ready drops while a MUL iterates or the result FIFO is full; the head result is held until cdb_grant.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   run, instruction_in dispatch strobe and {tag,opcode,dest,opB,opC}
//   ready              dispatch accepted this cycle when run && ready
//   store_cdb, solution FIFO head valid and {dest,tag,data}
//   cdb_grant          pops the head when store_cdb is high
//   illegal_op         one-cycle pulse after a memory-class opcode is accepted
module alu_functional_unit #(
  parameter int RESULT_DEPTH = 4,
  parameter int MUL_LAT      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [42:0] instruction_in,
  output logic        ready,
  output logic        store_cdb,
  output logic [22:0] solution,
  input  logic        cdb_grant,
  output logic        illegal_op
);

  localparam int PW = $clog2(RESULT_DEPTH);
  localparam int CW = $clog2(MUL_LAT);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(RESULT_DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  // Instruction fields
  logic [2:0]  in_tag;
  logic [3:0]  in_op;
  logic [3:0]  in_dest;
  logic [15:0] in_b;
  logic [15:0] in_c;

  assign in_tag  = instruction_in[42:40];
  assign in_op   = instruction_in[39:36];
  assign in_dest = instruction_in[35:32];
  assign in_b    = instruction_in[31:16];
  assign in_c    = instruction_in[15:0];

  // State
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   mul_b_q, mul_c_q;
  logic [2:0]    mul_tag_q;
  logic [3:0]    mul_dest_q;
  logic          illegal_q;

  logic [22:0]   mem_q [RESULT_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Control
  logic        accept;
  logic        is_illegal;
  logic        is_mul;
  logic        push_single;
  logic        push_mul;
  logic        push;
  logic        pop;
  logic [15:0] alu_res;
  logic [15:0] mul_res;
  logic [22:0] push_dat;

  assign ready       = (state_q == S_IDLE) && (count_q < FULL_CNT);
  assign accept      = run && ready;
  assign is_illegal  = in_op[3];
  assign is_mul      = (in_op[2:0] == 3'b111);
  assign push_single = accept && !is_illegal && !is_mul;
  assign push_mul    = (state_q == S_MUL) && (cnt_q == '0);
  // Never both: a single-cycle push needs IDLE, a MUL push needs MUL.
  assign push        = push_single || push_mul;
  assign store_cdb   = (count_q != '0);
  assign pop         = store_cdb && cdb_grant;

  // Single-cycle datapath; all results wrap modulo 2^16.
  always_comb begin
    alu_res = '0;
    case (in_op[2:0])
      3'b000:  alu_res = in_b + in_c;
      3'b001:  alu_res = in_b - in_c;
      3'b010:  alu_res = in_b & in_c;
      3'b011:  alu_res = in_b | in_c;
      3'b100:  alu_res = in_b ^ in_c;
      3'b101:  alu_res = in_b << in_c[3:0];
      3'b110:  alu_res = in_b >> in_c[3:0];
      default: alu_res = '0;
    endcase
  end

  // Only the low half of the product is kept.
  assign mul_res  = mul_b_q * mul_c_q;
  assign push_dat = push_mul ? {mul_dest_q, mul_tag_q, mul_res}
                             : {in_dest, in_tag, alu_res};

  // Head is masked so solution reads zero whenever the FIFO is empty.
  assign solution   = store_cdb ? mem_q[rd_ptr_q] : '0;
  assign illegal_op = illegal_q;

  // MUL sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (accept && !is_illegal && is_mul) begin
        state_d = S_MUL;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // FIFO pointer/count bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mul_b_q    <= '0;
      mul_c_q    <= '0;
      mul_tag_q  <= '0;
      mul_dest_q <= '0;
      illegal_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= accept && is_illegal;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (accept && !is_illegal && is_mul) begin
        mul_b_q    <= in_b;
        mul_c_q    <= in_c;
        mul_tag_q  <= in_tag;
        mul_dest_q <= in_dest;
      end
    end
  end

  // Storage needs no reset: stale entries are unreachable once count is cleared.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: tb/tb_alu_functional_unit.sv
module tb_alu_functional_unit;

  localparam int DEPTH = 4;
  localparam int MLAT  = 4;

  logic        clock;
  logic        reset;
  logic        run;
  logic [42:0] instruction_in;
  logic        ready;
  logic        store_cdb;
  logic [22:0] solution;
  logic        cdb_grant;
  logic        illegal_op;

  alu_functional_unit #(.RESULT_DEPTH(DEPTH), .MUL_LAT(MLAT)) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .instruction_in(instruction_in),
    .ready(ready),
    .store_cdb(store_cdb),
    .solution(solution),
    .cdb_grant(cdb_grant),
    .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [42:0] mk(input logic [2:0] tag, input logic [3:0] op,
                                     input logic [3:0] dest, input logic [15:0] b,
                                     input logic [15:0] c);
    return {tag, op, dest, b, c};
  endfunction

  // Reference arithmetic in plain integer terms.
  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] b, input logic [15:0] c);
    longint lb, lc, r;
    lb = longint'(b);
    lc = longint'(c);
    case (op)
      3'd0: r = (lb + lc) % 65536;
      3'd1: r = (lb - lc + 65536) % 65536;
      3'd2: r = longint'(b & c);
      3'd3: r = longint'(b | c);
      3'd4: r = longint'(b ^ c);
      3'd5: r = (lb * (longint'(1) << (lc % 16))) % 65536;
      3'd6: r = lb / (longint'(1) << (lc % 16));
      default: r = (lb * lc) % 65536;
    endcase
    return r[15:0];
  endfunction

  // Cycle-level model: a result queue plus a pending multiply with remaining latency.
  logic [22:0] mq[$];
  bit          m_valid = 0;
  bit          m_busy  = 0;
  int          m_left  = 0;
  logic [22:0] m_pend  = '0;
  bit          m_ill   = 0;

  always @(posedge clock) begin
    bit m_rdy;
    bit m_acc;
    logic [3:0] op;
    if (reset) begin
      mq.delete();
      m_busy  = 0;
      m_left  = 0;
      m_ill   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_rdy = !m_busy && (mq.size() < DEPTH);
      m_acc = run && m_rdy;
      op    = instruction_in[39:36];
      if (mq.size() > 0 && cdb_grant) void'(mq.pop_front());
      m_ill = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          mq.push_back(m_pend);
          m_busy = 0;
        end
      end else if (m_acc) begin
        if (op[3]) m_ill = 1;
        else begin
          m_pend = {instruction_in[35:32], instruction_in[42:40],
                    ref_alu(op[2:0], instruction_in[31:16], instruction_in[15:0])};
          if (op[2:0] == 3'd7) begin
            m_busy = 1;
            m_left = MLAT;
          end else begin
            mq.push_back(m_pend);
          end
        end
      end
    end
    #2;
    if (m_valid) begin
      check("model_ready", 32'(ready), 32'(!m_busy && (mq.size() < DEPTH)));
      check("model_store_cdb", 32'(store_cdb), 32'(mq.size() != 0));
      check("model_solution", 32'(solution), 32'((mq.size() != 0) ? mq[0] : 23'd0));
      check("model_illegal_op", 32'(illegal_op), 32'(m_ill));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #3;
  endtask

  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[9];
  logic [42:0] seq[5];
  logic [22:0] exp_sol[5];

  initial begin
    tbl[0] = '{3'd3, 4'd0, 4'd5, 16'h0010, 16'h0022, 16'h0032};
    tbl[1] = '{3'd1, 4'd1, 4'd2, 16'h0000, 16'h0001, 16'hFFFF};
    tbl[2] = '{3'd2, 4'd5, 4'd3, 16'h0001, 16'h0013, 16'h0008};
    tbl[3] = '{3'd4, 4'd6, 4'd4, 16'h8000, 16'h000F, 16'h0001};
    tbl[4] = '{3'd5, 4'd2, 4'd6, 16'hF0F0, 16'h3C3C, 16'h3030};
    tbl[5] = '{3'd6, 4'd3, 4'd7, 16'hF0F0, 16'h0F00, 16'hFFF0};
    tbl[6] = '{3'd7, 4'd4, 4'd8, 16'hFFFF, 16'h1234, 16'hEDCB};
    tbl[7] = '{3'd0, 4'd0, 4'd9, 16'hFFFF, 16'h0002, 16'h0001};
    tbl[8] = '{3'd1, 4'd6, 4'hF, 16'h1234, 16'h0000, 16'h1234};

    reset = 1'b1;
    run = 1'b0;
    cdb_grant = 1'b0;
    instruction_in = '0;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_store_cdb", 32'(store_cdb), 32'd0);
    check("rst_solution", 32'(solution), 32'd0);
    check("rst_illegal_op", 32'(illegal_op), 32'd0);

    // Single-cycle ops from the table
    for (int i = 0; i < 9; i++) begin
      run = 1'b1;
      instruction_in = mk(tbl[i].tag, tbl[i].op, tbl[i].dest, tbl[i].b, tbl[i].c);
      cyc();
      run = 1'b0;
      check("tbl_store_cdb", 32'(store_cdb), 32'd1);
      check("tbl_solution", 32'(solution), 32'({tbl[i].dest, tbl[i].tag, tbl[i].exp}));
      cdb_grant = 1'b1;
      cyc();
      cdb_grant = 1'b0;
      check("tbl_drained", 32'(store_cdb), 32'd0);
    end

    // MUL latency
    run = 1'b1;
    instruction_in = mk(3'd2, 4'd7, 4'd7, 16'h0100, 16'h0101);
    cyc();
    run = 1'b0;
    for (int i = 0; i < MLAT; i++) begin
      check("mul_busy_ready", 32'(ready), 32'd0);
      check("mul_busy_store", 32'(store_cdb), 32'd0);
      cyc();
    end
    check("mul_done_ready", 32'(ready), 32'd1);
    check("mul_done_store", 32'(store_cdb), 32'd1);
    check("mul_solution", 32'(solution), 32'({4'd7, 3'd2, 16'h0100}));
    cdb_grant = 1'b1;
    cyc();
    cdb_grant = 1'b0;

    // Fill to full, then pop while a dispatch is refused
    for (int k = 0; k < 5; k++) begin
      seq[k] = mk(3'(k), 4'd0, 4'(k + 10), 16'(k * 16'h0101), 16'h0003);
      exp_sol[k] = {4'(k + 10), 3'(k), 16'(k * 16'h0101 + 3)};
    end
    for (int k = 0; k < 4; k++) begin
      run = 1'b1;
      instruction_in = seq[k];
      cyc();
    end
    instruction_in = seq[4];
    check("full_ready", 32'(ready), 32'd0);
    check("full_head", 32'(solution), 32'(exp_sol[0]));
    cdb_grant = 1'b1;
    cyc();
    run = 1'b0;
    check("full_pop_ready", 32'(ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      check("full_drain_order", 32'(solution), 32'(exp_sol[k]));
      cyc();
    end
    cdb_grant = 1'b0;
    check("full_drained", 32'(store_cdb), 32'd0);

    // Simultaneous push/pop at count 2, repeated to cross the pointer wrap
    for (int r = 0; r < 3; r++) begin
      run = 1'b1;
      instruction_in = seq[0];
      cyc();
      instruction_in = seq[1];
      cyc();
      instruction_in = seq[2];
      cdb_grant = 1'b1;
      cyc();
      run = 1'b0;
      check("pp_head", 32'(solution), 32'(exp_sol[1]));
      cyc();
      check("pp_next", 32'(solution), 32'(exp_sol[2]));
      cyc();
      cdb_grant = 1'b0;
      check("pp_empty", 32'(store_cdb), 32'd0);
    end

    // Reset mid-MUL with results queued
    run = 1'b1;
    instruction_in = seq[0];
    cyc();
    instruction_in = seq[1];
    cyc();
    instruction_in = mk(3'd6, 4'd7, 4'd1, 16'h1234, 16'h0005);
    cyc();
    run = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort_store", 32'(store_cdb), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    for (int i = 0; i < MLAT + 2; i++) begin
      cyc();
      check("abort_no_late", 32'(store_cdb), 32'd0);
    end

    // Memory-class opcode
    run = 1'b1;
    instruction_in = mk(3'd1, 4'b1000, 4'd2, 16'h0001, 16'h0001);
    cyc();
    run = 1'b0;
    check("ill_pulse", 32'(illegal_op), 32'd1);
    check("ill_no_push", 32'(store_cdb), 32'd0);
    check("ill_ready", 32'(ready), 32'd1);
    cyc();
    check("ill_clear", 32'(illegal_op), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  op;
      logic [15:0] b, c;
      op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      b = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      c = 16'($urandom);
      run = ($urandom_range(0, 9) < 7);
      instruction_in = mk(3'($urandom), op, 4'($urandom), b, c);
      cdb_grant = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    run = 1'b0;
    cdb_grant = 1'b1;
    repeat (MLAT + DEPTH + 4) cyc();
    check("final_empty", 32'(store_cdb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
